// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and size helpers.
// The checksum feature is selected by `IMEM_LOADER_CHECKSUM_EN; the CSUM encoding always exists.
package imem_loader_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// master = stream source / memory side, slave = loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              load_start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  modport master (
    output load_start, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
  );

  modport slave (
    input  load_start, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Shifts stream bytes MSB-first into an instruction word and tracks the byte index.
module byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_shift,
  input  logic              i_clear,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_full
);
  localparam int unsigned BYTES = bytes_of(DATA_W);
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_word;

  // o_word_full means the pending shift supplies the last byte of the word
  assign o_word_full = (r_idx == IDX_W'(BYTES - 1));
  assign o_word      = r_word;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_shift) begin
      r_idx  <= o_word_full ? '0 : r_idx + IDX_W'(1);
      r_word <= {r_word[DATA_W-9:0], i_byte};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Loads LEN-prefixed byte frames into instruction memory and holds the CPU meanwhile.
// Optional trailing checksum byte when `IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  imem_loader_if.slave   bus
);
  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CSUM;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t            r_state, w_state_nxt;
  logic              r_byte_ready, r_mem_we, r_cpu_hold, r_load_done, r_load_error;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [CNT_W-1:0]  r_count, w_count_nxt, r_len, w_len_nxt;
  logic              w_err_nxt, w_hold_nxt;
  logic              w_accept, w_shift, w_clear, w_word_full, w_len_over;
  logic [DATA_W-1:0] w_word, w_word_next;

  assign w_accept    = bus.byte_valid && r_byte_ready;
  assign w_len_over  = (32'(bus.byte_in) > DEPTH);
  assign w_word_next = {w_word[DATA_W-9:0], bus.byte_in};

  byte_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk         (clk),
    .reset       (reset),
    .i_shift     (w_shift),
    .i_clear     (w_clear),
    .i_byte      (bus.byte_in),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum, w_csum;
  assign w_csum = r_sum + bus.byte_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
    end else if (w_accept && r_state == S_LEN) begin
      r_sum <= bus.byte_in;
    end else if (w_accept && r_state == S_DATA) begin
      r_sum <= w_csum;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_len_nxt   = r_len;
    w_err_nxt   = r_load_error;
    w_hold_nxt  = r_cpu_hold;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.load_start) begin
        w_state_nxt = S_LEN;
        w_err_nxt   = 1'b0;
        w_count_nxt = '0;
        w_hold_nxt  = 1'b1;
      end
      S_LEN: if (w_accept) begin
        w_clear   = 1'b1;
        w_len_nxt = CNT_W'(bus.byte_in);
        if (w_len_over) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (bus.byte_in == 8'd0) begin
          w_state_nxt = S_AFTER;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: if (w_accept) begin
        w_shift = 1'b1;
        if (w_word_full) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_count_nxt = r_count + CNT_W'(1);
        w_state_nxt = (w_count_nxt == r_len) ? S_AFTER : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (w_accept) begin
        if (w_csum != 8'd0) w_err_nxt = 1'b1;
        w_state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        w_hold_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_count      <= '0;
      r_len        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_byte_ready <= (w_state_nxt == S_LEN) || (w_state_nxt == S_DATA) || (w_state_nxt == S_CSUM);
      r_mem_we     <= (w_state_nxt == S_WRITE);
      r_load_done  <= (w_state_nxt == S_DONE);
      r_cpu_hold   <= w_hold_nxt;
      r_load_error <= w_err_nxt;
      r_count      <= w_count_nxt;
      r_len        <= w_len_nxt;
      if (w_shift && w_word_full) begin
        r_mem_addr  <= r_count[ADDR_W-1:0];
        r_mem_wdata <= w_word_next;
      end
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.cpu_hold   = r_cpu_hold;
  assign bus.load_done  = r_load_done;
  assign bus.load_error = r_load_error;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 64x32 instruction memory and a PC-driven fetch port.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] imem [DEPTH];
  logic [5:0]  pc;
  logic        pc_clr = 1'b0;
  logic        pc_run = 1'b0;
  logic [31:0] fetch;
  logic [31:0] exp4 [DEPTH];
  logic [7:0]  tx_sum;
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int ready_viol = 0;

  always @(posedge clk) begin
    if (reset || pc_clr) pc <= '0;
    else if (pc_run && !bus.cpu_hold) pc <= pc + 6'd1;
  end
  assign fetch = imem[pc];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      imem[bus.mem_addr] = bus.mem_wdata;
      we_cnt++;
      if (bus.byte_ready !== 1'b0) ready_viol++;
    end
    if (bus.load_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    tx_sum = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n = 0;
    bus.byte_valid = 1'b0;
    if (gap != 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    while (bus.byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 100)
      else begin
        errors++;
        $error("FAIL byte_accept_timeout: observed %0d waits expected <100", n);
      end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    tx_sum = tx_sum + b;
  endtask

  task automatic send_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00 - tx_sum, 0);
`endif
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (bus.load_done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 1000)
      else begin
        errors++;
        $error("FAIL done_timeout: observed %0d cycles expected <1000", n);
      end
  endtask

  initial begin
    int d0;
    bus.load_start = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) imem[i] = 32'hDEADBEEF;

    // reset
    #12;
    check("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("rst_we",    {31'd0, bus.mem_we},     32'd0);
    check("rst_hold",  {31'd0, bus.cpu_hold},   32'd0);
    check("rst_done",  {31'd0, bus.load_done},  32'd0);
    check("rst_err",   {31'd0, bus.load_error}, 32'd0);
    check("rst_addr",  {26'd0, bus.mem_addr},   32'd0);
    check("rst_wdata", bus.mem_wdata,           32'd0);
    #8 reset = 1'b0;
    @(posedge clk); #1;

    // test 1: two words
    we_cnt = 0; done_cnt = 0;
    start_load();
    check("t1_hold", {31'd0, bus.cpu_hold}, 32'd1);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
    check("t1_we_latency", {31'd0, bus.mem_we},     32'd1);
    check("t1_we_ready",   {31'd0, bus.byte_ready}, 32'd0);
    check("t1_addr0",      {26'd0, bus.mem_addr},   32'd0);
    check("t1_wdata0",     bus.mem_wdata,           32'h12345678);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    send_csum();
    wait_done();
    check("t1_err", {31'd0, bus.load_error}, 32'd0);
    @(posedge clk); #1;
    check("t1_hold_low", {31'd0, bus.cpu_hold},  32'd0);
    check("t1_done_low", {31'd0, bus.load_done}, 32'd0);
    check("t1_mem0",     imem[0],                32'h12345678);
    check("t1_mem1",     imem[1],                32'hAABBCCDD);
    check("t1_we_cnt",   we_cnt,                 32'd2);
    check("t1_done_cnt", done_cnt,               32'd1);
    check("t1_addr_hold",  {26'd0, bus.mem_addr}, 32'd1);
    check("t1_wdata_hold", bus.mem_wdata,         32'hAABBCCDD);
    pc_clr = 1'b1; @(posedge clk); #1; pc_clr = 1'b0; pc_run = 1'b1;
    check("t1_fetch0", fetch, 32'h12345678);
    @(posedge clk); #1;
    check("t1_fetch1", fetch, 32'hAABBCCDD);
    pc_run = 1'b0;

    // test 2: empty frame
    we_cnt = 0; done_cnt = 0;
    start_load();
    send_byte(8'h00, 0);
    send_csum();
    check("t2_done", {31'd0, bus.load_done},  32'd1);
    check("t2_err",  {31'd0, bus.load_error}, 32'd0);
    @(posedge clk); #1;
    check("t2_we_cnt", we_cnt, 32'd0);

    // test 3: oversize length, then error clears on next start
    we_cnt = 0;
    start_load();
    send_byte(8'h41, 0);
    check("t3_done", {31'd0, bus.load_done},  32'd1);
    check("t3_err",  {31'd0, bus.load_error}, 32'd1);
    @(posedge clk); #1;
    check("t3_err_sticky", {31'd0, bus.load_error}, 32'd1);
    check("t3_we_cnt", we_cnt, 32'd0);
    start_load();
    check("t3_err_clr", {31'd0, bus.load_error}, 32'd0);
    send_byte(8'h00, 0);
    send_csum();
    wait_done();
    @(posedge clk); #1;

    // test 4: full memory with random stalls
    we_cnt = 0; ready_viol = 0;
    for (int i = 0; i < int'(DEPTH); i++) exp4[i] = $urandom;
    start_load();
    send_byte(8'h40, $urandom_range(0, 2));
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int k = 3; k >= 0; k--) begin
        logic [31:0] w;
        w = exp4[i];
        send_byte(w[k*8 +: 8], $urandom_range(0, 2));
      end
    end
    send_csum();
    wait_done();
    check("t4_err", {31'd0, bus.load_error}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < int'(DEPTH); i++) check($sformatf("t4_mem%0d", i), imem[i], exp4[i]);
    check("t4_we_cnt",     we_cnt,                32'd64);
    check("t4_ready_viol", ready_viol,            32'd0);
    check("t4_last_addr",  {26'd0, bus.mem_addr}, 32'd63);

    // test 5: reset after six bytes of a two-word frame
    d0 = done_cnt;
    start_load();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("t5_we",    {31'd0, bus.mem_we},     32'd0);
    check("t5_hold",  {31'd0, bus.cpu_hold},   32'd0);
    check("t5_done",  {31'd0, bus.load_done},  32'd0);
    check("t5_err",   {31'd0, bus.load_error}, 32'd0);
    check("t5_addr",  {26'd0, bus.mem_addr},   32'd0);
    check("t5_wdata", bus.mem_wdata,           32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("t5_mem0",     imem[0],  32'h11223344);
    check("t5_mem1",     imem[1],  exp4[1]);
    check("t5_no_done",  done_cnt, d0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // test 6: checksum good and bad, load_start ignored mid-frame
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    start_load();
    check("t6_ign_hold",  {31'd0, bus.cpu_hold},   32'd1);
    check("t6_ign_ready", {31'd0, bus.byte_ready}, 32'd1);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'hF5, 0);
    wait_done();
    check("t6_good_err", {31'd0, bus.load_error}, 32'd0);
    @(posedge clk); #1;
    check("t6_mem0", imem[0], 32'h01020304);
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    wait_done();
    check("t6_bad_err", {31'd0, bus.load_error}, 32'd1);
    @(posedge clk); #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
